// File: rtl/red_pitaya_pwm_meas.sv
// PWM bitstream decoder: counts high cycles over a window of NSUB subperiods
// of FULL+1 cycles each, and reports the window total plus the smallest and
// largest per-subperiod high counts. Windows are framed by sync_i, which is
// expected on the last cycle of every window.
// Optional build macro PWM_MEAS_INSYNC_EN adds a two-flop input synchronizer
// on pwm_i and sync_i, which adds two cycles to every input-to-output latency.
module red_pitaya_pwm_meas #(
   parameter logic [7:0]  FULL = 8'd255,
   parameter int unsigned NSUB = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   input  logic        pwm_i,
   input  logic        sync_i,
   output logic [12:0] val_o,
   output logic [8:0]  sub_min_o,
   output logic [8:0]  sub_max_o,
   output logic        val_vld_o,
   output logic        sync_err_o
);

   localparam int unsigned IW = (NSUB > 1) ? $clog2(NSUB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NSUB - 1);

   typedef enum logic {SEARCH, RUN} state_t;

   state_t          state;
   logic            pwm_s;
   logic            sync_s;
   logic [7:0]      sub_cnt;
   logic [IW-1:0]   sub_idx;
   logic [8:0]      sub_hi;
   logic [12:0]     acc;
   logic [8:0]      min_r;
   logic [8:0]      max_r;

   logic [8:0]      hi_nxt;
   logic [12:0]     acc_nxt;
   logic [8:0]      min_nxt;
   logic [8:0]      max_nxt;
   logic            last_sub;
   logic            last_win;
   logic            run;
   logic            err_now;
   logic            pub;
   logic            clr;

`ifdef PWM_MEAS_INSYNC_EN
   logic [1:0] pwm_ff;
   logic [1:0] sync_ff;

   // Two-flop synchronizer; both inputs share the same depth so their alignment is kept
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_ff  <= '0;
         sync_ff <= '0;
      end else begin
         pwm_ff  <= {pwm_ff[0], pwm_i};
         sync_ff <= {sync_ff[0], sync_i};
      end
   end

   assign pwm_s  = pwm_ff[1];
   assign sync_s = sync_ff[1];
`else
   assign pwm_s  = pwm_i;
   assign sync_s = sync_i;
`endif

   // Next-value terms that include the current sample, plus window framing decodes
   always_comb begin
      hi_nxt   = sub_hi + {8'd0, pwm_s};
      acc_nxt  = acc + {12'd0, pwm_s};
      last_sub = (sub_cnt == FULL);
      last_win = last_sub && (sub_idx == LAST_IDX);
      // the first subperiod of a window seeds min/max instead of comparing
      min_nxt  = ((sub_idx == '0) || (hi_nxt < min_r)) ? hi_nxt : min_r;
      max_nxt  = ((sub_idx == '0) || (hi_nxt > max_r)) ? hi_nxt : max_r;
      run      = en_i && (state == RUN);
      err_now  = run && sync_s && !last_win;
      pub      = run && last_win;
      clr      = !run || err_now || pub;
   end

   // Subperiod/window counters and accumulators; cleared outside RUN, on early sync and after publishing
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sub_cnt <= '0;
         sub_idx <= '0;
         sub_hi  <= '0;
         acc     <= '0;
         min_r   <= '0;
         max_r   <= '0;
      end else begin
         acc <= acc_nxt;
         if (last_sub) begin
            sub_cnt <= '0;
            sub_idx <= sub_idx + IW'(1);
            sub_hi  <= '0;
            min_r   <= min_nxt;
            max_r   <= max_nxt;
         end else begin
            sub_cnt <= sub_cnt + 8'd1;
            sub_hi  <= hi_nxt;
         end
      end
   end

   // SEARCH/RUN state machine with registered result and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SEARCH;
         val_o      <= '0;
         sub_min_o  <= '0;
         sub_max_o  <= '0;
         val_vld_o  <= 1'b0;
         sync_err_o <= 1'b0;
      end else begin
         val_vld_o  <= pub;
         sync_err_o <= err_now || (pub && !sync_s);
         if (pub) begin
            val_o     <= acc_nxt;
            sub_min_o <= min_nxt;
            sub_max_o <= max_nxt;
         end
         if (!en_i) begin
            state <= SEARCH;
         end else begin
            case (state)
               SEARCH: if (sync_s) state <= RUN;
               RUN:    if (pub && !sync_s) state <= SEARCH;
               default: state <= SEARCH;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_red_pitaya_pwm_meas.sv
// Directed bench for red_pitaya_pwm_meas (FULL=255, NSUB=16). Windows are
// described by a table of {high cycles per subperiod for subperiods 0-7 and
// 8-15, expected total, min, max}; framing corner cases (early sync, reset
// mid-window, missing sync, enable low) are hand-written sequences.
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_red_pitaya_pwm_meas;

   // extra input latency when the design is built with its input synchronizer
`ifdef PWM_MEAS_INSYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   localparam int WIN = 4096;

   logic        clk;
   logic        rst;
   logic        en_i;
   logic        pwm_i;
   logic        sync_i;
   logic [12:0] val_o;
   logic [8:0]  sub_min_o;
   logic [8:0]  sub_max_o;
   logic        val_vld_o;
   logic        sync_err_o;

   red_pitaya_pwm_meas #(
      .FULL (8'd255),
      .NSUB (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en_i),
      .pwm_i      (pwm_i),
      .sync_i     (sync_i),
      .val_o      (val_o),
      .sub_min_o  (sub_min_o),
      .sub_max_o  (sub_max_o),
      .val_vld_o  (val_vld_o),
      .sync_err_o (sync_err_o)
   );

   typedef struct {
      int hi_a;
      int hi_b;
      int val;
      int mn;
      int mx;
   } vec_t;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int vld_n  = 0;
   int err_n  = 0;
   int vld_q[$];

   // pending publication check, armed when a window's last cycle is driven
   int pend   = 0;
   int e_vld, e_err, e_val, e_mn, e_mx, e_nvld;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // record every pulse with the index of the rising edge that produced it
   always @(posedge clk) begin
      #1;
      if (val_vld_o === 1'b1) begin
         vld_n++;
         vld_q.push_back(cyc);
      end
      if (sync_err_o === 1'b1) err_n++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic check_pub();
      chk("pub_vld", {31'd0, val_vld_o}, e_vld);
      chk("pub_err", {31'd0, sync_err_o}, e_err);
      chk("pub_val", {19'd0, val_o}, e_val);
      chk("pub_min", {23'd0, sub_min_o}, e_mn);
      chk("pub_max", {23'd0, sub_max_o}, e_mx);
      chk("pub_count", vld_n, e_nvld);
   endtask

   task automatic arm(input int v, input int e, input int val, input int mn, input int mx, input int nv);
      pend   = LAT + 1;
      e_vld  = v;
      e_err  = e;
      e_val  = val;
      e_mn   = mn;
      e_mx   = mx;
      e_nvld = nv;
   endtask

   // drive one cycle of input, then wait until its result can be observed
   task automatic step(input logic p, input logic s);
      pwm_i  = p;
      sync_i = s;
      @(negedge clk);
      if (pend > 0) begin
         pend--;
         if (pend == 0) check_pub();
      end
   endtask

   // one full window; pwm high for the first hi cycles of each subperiod
   task automatic run_window(input int ha, input int hb, input logic ls,
                             input int ev, input int emn, input int emx, input int nv);
      for (int s = 0; s < 16; s++) begin
         for (int c = 0; c < 256; c++) begin
            if (s == 15 && c == 255) begin
               arm(1, ls ? 0 : 1, ev, emn, emx, nv);
               step(c < hb, ls);
            end else begin
               step(c < ((s < 8) ? ha : hb), 1'b0);
            end
         end
      end
   endtask

   vec_t vecs[6];
   int   es_edge;
   int   rs_edge;
   int   nv_hold;

   initial begin
      vecs[0] = '{hi_a: 256, hi_b: 256, val: 4096, mn: 256, mx: 256};
      vecs[1] = '{hi_a: 101, hi_b: 101, val: 1616, mn: 101, mx: 101};
      vecs[2] = '{hi_a: 100, hi_b: 101, val: 1608, mn: 100, mx: 101};
      vecs[3] = '{hi_a: 0,   hi_b: 0,   val: 0,    mn: 0,   mx: 0};
      vecs[4] = '{hi_a: 101, hi_b: 100, val: 1608, mn: 100, mx: 101};
      vecs[5] = '{hi_a: 1,   hi_b: 255, val: 2048, mn: 1,   mx: 255};

      rst    = 1'b1;
      en_i   = 1'b1;
      pwm_i  = 1'b0;
      sync_i = 1'b0;
      repeat (3) step(1'b1, 1'b1);
      chk("rst_val", {19'd0, val_o}, 0);
      chk("rst_min", {23'd0, sub_min_o}, 0);
      chk("rst_max", {23'd0, sub_max_o}, 0);
      chk("rst_vld", {31'd0, val_vld_o}, 0);
      chk("rst_err", {31'd0, sync_err_o}, 0);
      rst = 1'b0;
      repeat (5) step(1'b1, 1'b0);
      chk("search_no_vld", vld_n, 0);

      // back-to-back windows, each closed by a sync on its last cycle
      step(1'b0, 1'b1);
      for (int i = 0; i < 6; i++)
         run_window(vecs[i].hi_a, vecs[i].hi_b, 1'b1, vecs[i].val, vecs[i].mn, vecs[i].mx, i + 1);
      repeat (LAT) step(1'b0, 1'b0);
      for (int i = 1; i < 6; i++)
         chk("vld_period", vld_q[i] - vld_q[i-1], WIN);
      chk("table_no_err", err_n, 0);

      // early sync at window cycle 1000: error pulse, partial window dropped
      repeat (1000) step(1'b1, 1'b0);
      es_edge = cyc + 1;
      nv_hold = vld_n;
      arm(0, 1, 2048, 1, 255, nv_hold);
      step(1'b1, 1'b1);
      run_window(101, 101, 1'b1, 1616, 101, 101, nv_hold + 1);
      repeat (LAT) step(1'b0, 1'b0);
      // rising edge 4096 after the early sync's edge: visible in the 4097th cycle
      chk("early_gap", vld_q[$] - es_edge, WIN + LAT);

      // reset at window cycle 2000 abandons the window and clears outputs
      repeat (2000 - LAT) step(1'b1, 1'b0);
      rst = 1'b1;
      step(1'b1, 1'b0);
      rst = 1'b0;
      chk("midrst_val", {19'd0, val_o}, 0);
      chk("midrst_min", {23'd0, sub_min_o}, 0);
      chk("midrst_max", {23'd0, sub_max_o}, 0);
      chk("midrst_vld", {31'd0, val_vld_o}, 0);
      chk("midrst_err", {31'd0, sync_err_o}, 0);

      // sync 50 cycles after reset, then a window whose closing sync is missing
      repeat (49) step(1'b1, 1'b0);
      rs_edge = cyc + 1;
      nv_hold = vld_n;
      step(1'b0, 1'b1);
      run_window(50, 200, 1'b0, 2000, 50, 200, nv_hold + 1);
      repeat (LAT) step(1'b0, 1'b0);
      chk("rst_sync_gap", vld_q[$] - rs_edge, WIN + LAT);

      // back in SEARCH: nothing published without a new sync
      nv_hold = vld_n;
      repeat (4200) step(1'b1, 1'b0);
      chk("search_hold_vld", vld_n, nv_hold);
      chk("search_hold_val", {19'd0, val_o}, 2000);

      // enable low: sync ignored, outputs kept
      en_i = 1'b0;
      repeat (4) step(1'b1, 1'b1);
      repeat (LAT + 2) step(1'b1, 1'b0);
      chk("en_low_vld", vld_n, nv_hold);
      chk("en_low_max", {23'd0, sub_max_o}, 200);
      chk("err_total", err_n, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
